// File: rtl/arm_mem_arbiter.sv
// rtl/arm_mem_arbiter.sv - single-port unified memory arbiter for ARM fetch and load/store ports
//
// Purpose:
//   Shares one single-port memory between the instruction-fetch port (if_*)
//   and the load/store data port (d_*). Each access runs ISSUE -> WAIT
//   (MEM_LAT cycles) -> RESP. Arbitration happens in IDLE and RESP. Data wins
//   over fetch.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   if_req/if_addr     fetch request, held until if_gnt
//   if_gnt             one-cycle fetch grant (ISSUE cycle)
//   if_rvalid/if_rdata fetch completion and read data (held until next rvalid)
//   d_req/d_we/d_addr/d_wdata/d_be  data request, held until d_gnt
//   d_gnt              one-cycle data grant (ISSUE cycle)
//   d_rvalid/d_rdata   data completion; d_rdata is 0 for a store
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be  memory command, one cycle per access
//   mem_rdata          memory read data, valid MEM_LAT cycles after mem_en
//   busy               high in every state except IDLE
//
// Build option:
//   ARB_STARVE_GUARD_EN  when defined, a fetch is forced through after
//                        MAX_DATA_BURST consecutive data grants made while a
//                        fetch was waiting.

module arm_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MEM_LAT        = 2,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam int             BE_W      = DATA_W / 8;
  localparam logic [3:0]     LAST_WAIT = 4'(MEM_LAT - 1);
  localparam logic [3:0]     MAX_BURST = 4'(MAX_DATA_BURST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic                owner_d_q, owner_d_d;   // 1: data port owns the access
  logic                store_q, store_d;       // owned access is a store
  logic                if_gnt_q, if_gnt_d;
  logic                d_gnt_q, d_gnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic arb_en;
  logic force_if;
  logic pick_d;
  logic pick_if;

  // Arbitration points: IDLE, and RESP for back-to-back accesses.
  assign arb_en  = (state_q == S_IDLE) || (state_q == S_RESP);
  assign pick_d  = arb_en && d_req && !force_if;
  assign pick_if = arb_en && if_req && !pick_d;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  // Counts data grants that overtook a waiting fetch. Never exceeds
  // MAX_BURST: reaching it forces the next arbitration to the fetch port,
  // which clears it.
  assign force_if = if_req && (starve_q == MAX_BURST);

  always_comb begin
    starve_d = starve_q;
    if (arb_en) begin
      if (!if_req || pick_if) begin
        starve_d = 4'd0;
      end else if (pick_d) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Strict data priority; the burst limit only matters with the guard built in.
  logic unused_burst_cfg;
  assign force_if         = 1'b0;
  assign unused_burst_cfg = ^MAX_BURST;
`endif

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    owner_d_d   = owner_d_q;
    store_d     = store_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_be_d    = '0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_ISSUE: begin
        state_d    = S_WAIT;
        wait_cnt_d = 4'd0;
      end
      S_WAIT: begin
        if (wait_cnt_q == LAST_WAIT) begin
          // mem_rdata is valid in this last WAIT cycle; capture it into the
          // owner's rdata register so it appears with rvalid in RESP.
          state_d = S_RESP;
          if (owner_d_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = store_q ? '0 : mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A win latches the request fields straight into the registered memory
    // command, so later requester changes cannot affect this access.
    if (pick_d) begin
      state_d     = S_ISSUE;
      owner_d_d   = 1'b1;
      store_d     = d_we;
      d_gnt_d     = 1'b1;
      mem_en_d    = 1'b1;
      mem_we_d    = d_we;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      mem_be_d    = d_we ? d_be : {BE_W{1'b1}};
    end else if (pick_if) begin
      state_d     = S_ISSUE;
      owner_d_d   = 1'b0;
      store_d     = 1'b0;
      if_gnt_d    = 1'b1;
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
      mem_be_d    = {BE_W{1'b1}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= 4'd0;
      owner_d_q   <= 1'b0;
      store_q     <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      owner_d_q   <= owner_d_d;
      store_q     <= store_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_arm_mem_arbiter.sv
// tb/tb_arm_mem_arbiter.sv - self-checking bench for arm_mem_arbiter

module tb_arm_mem_arbiter;

  localparam int LAT  = 2;
  localparam int MAXB = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        if_req1;
  logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1, busy1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [3:0]  mem_be1;

  int total = 0;
  int bad   = 0;
  int tcyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  arm_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MAX_DATA_BURST(MAXB)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
  );

  arm_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_DATA_BURST(MAXB)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(32'h8), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_be(4'h0),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_be(mem_be1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'hE3A00001;
      1:       return 32'hE2811001;
      4:       return 32'hDEADBEEF;
      16:      return 32'hCAFEF00D;
      default: return 32'hA5A50000 | 32'(i * 4);
    endcase
  endfunction

  // Memory seen by the main DUT: read data is only valid exactly LAT cycles
  // after mem_en; otherwise a poison value is driven.
  logic [31:0] mem_drv [0:63];
  logic        sh_v [1:LAT];
  logic [5:0]  sh_a [1:LAT];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem_drv[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    sh_v[1] <= mem_en && !mem_we;
    sh_a[1] <= mem_addr[7:2];
    for (int k = 2; k <= LAT; k++) begin
      sh_v[k] <= sh_v[k-1];
      sh_a[k] <= sh_a[k-1];
    end
  end
  assign mem_rdata = sh_v[LAT] ? mem_drv[sh_a[LAT]] : 32'hBAD0BAD0;

  logic        sh1_v = 1'b0;
  logic [31:0] sh1_a = 32'h0;
  always @(posedge clk) begin
    sh1_v <= mem_en1;
    sh1_a <= mem_addr1;
  end
  assign mem_rdata1 = sh1_v ? (sh1_a ^ 32'h5A5A0000) : 32'hBAD0BAD0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, tcyc);
    end
  endtask

  function automatic bit sel(input int w);
    case (w)
      0:       return d_gnt;
      1:       return if_gnt;
      2:       return d_rvalid;
      3:       return if_rvalid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int max_cyc, output int at);
    at = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (sel(which)) begin
        at = tcyc;
        break;
      end
    end
    if (at < 0) begin
      total++;
      bad++;
      $display("FAIL wait_event_%0d: timed out after %0d cycles", which, max_cyc);
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy still %0b after 40 cycles", busy);
    end
  endtask

  // Transaction-level reference: one access at a time; an access won in
  // cycle a occupies [a+1, a+LAT+2], grant/mem_en in its first cycle and
  // rvalid in its last, and the arbiter may decide again in that last cycle.
  logic [31:0] mmem [0:63];
  bit          m_on = 1'b0;
  bit          m_act = 1'b0;
  int          m_iss, m_rsp, m_free, m_cnt;
  bit          m_own_d, m_we;
  logic [31:0] m_addr, m_wdata, m_data, m_ifrd, m_drd;
  logic [3:0]  m_be;

  always @(negedge clk) begin
    int  c;
    bit  e_g, e_rv, frc, pd, pi;
    c = tcyc;
    if (m_on) begin
      e_g  = m_act && (c == m_iss);
      e_rv = m_act && (c == m_rsp);
      if (e_g) begin
        if (m_we) begin
          for (int b = 0; b < 4; b++)
            if (m_be[b]) mmem[m_addr[7:2]][8*b +: 8] = m_wdata[8*b +: 8];
        end else begin
          m_data = mmem[m_addr[7:2]];
        end
      end
      if (e_rv) begin
        if (m_own_d) m_drd = m_we ? 32'h0 : m_data;
        else         m_ifrd = m_data;
      end
      chk("d_gnt", d_gnt, e_g && m_own_d);
      chk("if_gnt", if_gnt, e_g && !m_own_d);
      chk("mem_en", mem_en, e_g);
      chk("d_rvalid", d_rvalid, e_rv && m_own_d);
      chk("if_rvalid", if_rvalid, e_rv && !m_own_d);
      chk("busy", busy, m_act && c >= m_iss && c <= m_rsp);
      chk("d_rdata", d_rdata, m_drd);
      chk("if_rdata", if_rdata, m_ifrd);
      chk("mem_we", mem_we, e_g && m_we);
      if (e_g) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_be", mem_be, m_we ? m_be : 4'hF);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
    end
    if (rst) begin
      m_on   = 1'b1;
      m_act  = 1'b0;
      m_ifrd = 32'h0;
      m_drd  = 32'h0;
      m_cnt  = 0;
      m_free = c + 1;
    end else if (m_on && c >= m_free) begin
      frc = GUARD && if_req && (m_cnt == MAXB);
      pd  = d_req && !frc;
      pi  = if_req && !pd;
      if (!if_req || pi) m_cnt = 0;
      else if (pd)       m_cnt = m_cnt + 1;
      if (pd || pi) begin
        m_act   = 1'b1;
        m_iss   = c + 1;
        m_rsp   = c + 2 + LAT;
        m_free  = m_rsp;
        m_own_d = pd;
        m_we    = pd && d_we;
        m_addr  = pd ? d_addr : if_addr;
        m_wdata = d_wdata;
        m_be    = d_be;
      end
    end
  end

  // MEM_LAT=1 instance: continuous fetches.
  int last_g1 = -1, last_en1 = -1, n_g1 = 0;
  always @(negedge clk) begin
    if (rst) begin
      last_g1  = -1;
      last_en1 = -1;
    end else begin
      if (if_rvalid1) begin
        chk("l1_rv_latency", 64'(tcyc - last_en1), 64'd2);
        chk("l1_rdata", if_rdata1, 32'h5A5A0008);
      end
      if (if_gnt1) begin
        if (last_g1 >= 0) chk("l1_gnt_period", 64'(tcyc - last_g1), 64'd3);
        last_g1 = tcyc;
        n_g1++;
      end
      if (mem_en1) last_en1 = tcyc;
    end
  end

  initial begin
    int tg, tv, ti, nd, ni, nbefore, nrv;
    for (int i = 0; i < 64; i++) begin
      mem_drv[i] = init_word(i);
      mmem[i]    = init_word(i);
    end
    for (int k = 1; k <= LAT; k++) begin
      sh_v[k] = 1'b0;
      sh_a[k] = 6'd0;
    end
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; if_req1 = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_mem_en", mem_en, 1'b0);
    chk("reset_d_rdata", d_rdata, 32'h0);
    chk("reset_if_rdata", if_rdata, 32'h0);
    if_req1 = 1'b1;

    // single load
    @(posedge clk); #1 d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    wait_for(0, 20, tg);
    chk("t1_mem_addr", mem_addr, 32'h10);
    @(posedge clk); #1 d_req = 1'b0;
    wait_for(2, 20, tv);
    chk("t1_latency", 64'(tv - tg), 64'd3);
    chk("t1_rdata", d_rdata, 32'hDEADBEEF);
    chk("t1_busy_resp", busy, 1'b1);
    wait_idle();

    // store
    @(posedge clk); #1 d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678; d_be = 4'b0011;
    wait_for(0, 20, tg);
    chk("t2_mem_we", mem_we, 1'b1);
    chk("t2_mem_be", mem_be, 4'b0011);
    @(posedge clk); #1 d_req = 1'b0; d_we = 1'b0;
    wait_for(2, 20, tv);
    chk("t2_latency", 64'(tv - tg), 64'd3);
    chk("t2_rdata_zero", d_rdata, 32'h0);
    chk("t2_if_rvalid", if_rvalid, 1'b0);
    wait_idle();

    // read back the partially written word
    @(posedge clk); #1 d_req = 1'b1; d_addr = 32'h20;
    wait_for(0, 20, tg);
    @(posedge clk); #1 d_req = 1'b0;
    wait_for(2, 20, tv);
    chk("t3_merged", d_rdata, 32'hA5A55678);
    wait_idle();

    // simultaneous requests: data first
    @(posedge clk); #1 d_req = 1'b1; d_addr = 32'h40; if_req = 1'b1; if_addr = 32'h0;
    wait_for(0, 20, tg);
    chk("t4_first_addr", mem_addr, 32'h40);
    @(posedge clk); #1 d_req = 1'b0;
    wait_for(1, 20, ti);
    chk("t4_fetch_gap", 64'(ti - tg), 64'd4);
    @(posedge clk); #1 if_req = 1'b0;
    wait_for(3, 20, tv);
    chk("t4_fetch_data", if_rdata, 32'hE3A00001);
    chk("t4_d_hold", d_rdata, 32'hCAFEF00D);
    wait_idle();

    // starvation window of 40 cycles = 10 accesses
    @(posedge clk); #1 d_req = 1'b1; d_addr = 32'h40; if_req = 1'b1; if_addr = 32'h4;
    nd = 0; ni = 0; nbefore = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d_gnt) begin
        nd++;
        if (ni == 0) nbefore++;
      end
      if (if_gnt) ni++;
    end
    @(posedge clk); #1 d_req = 1'b0;
    chk("t5_data_before_fetch", 64'(nbefore), GUARD ? 64'd4 : 64'd10);
    chk("t5_fetch_grants", 64'(ni), GUARD ? 64'd2 : 64'd0);
    chk("t5_data_grants", 64'(nd), GUARD ? 64'd8 : 64'd10);
    wait_for(1, 20, ti);
    @(posedge clk); #1 if_req = 1'b0;
    wait_idle();

    // reset during WAIT
    @(posedge clk); #1 d_req = 1'b1; d_addr = 32'h40;
    wait_for(0, 20, tg);
    @(posedge clk); #1 d_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy, 1'b0);
    chk("t6_d_rdata", d_rdata, 32'h0);
    chk("t6_mem_en", mem_en, 1'b0);
    nrv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (d_rvalid || if_rvalid) nrv++;
    end
    chk("t6_no_rvalid", 64'(nrv), 64'd0);

    // normal access after reset
    @(posedge clk); #1 d_req = 1'b1; d_addr = 32'h10;
    wait_for(0, 20, tg);
    @(posedge clk); #1 d_req = 1'b0;
    wait_for(2, 20, tv);
    chk("t7_latency", 64'(tv - tg), 64'd3);
    chk("t7_rdata", d_rdata, 32'hDEADBEEF);
    wait_idle();

    if_req1 = 1'b0;
    repeat (4) @(posedge clk);
    chk("l1_enough_grants", 64'(n_g1 >= 10), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
